// File: rtl/sp_ram_be_if.sv
// Bus between the load/store unit (master) and the byte-enable RAM (slave).
interface sp_ram_be_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int BYTE_W = 8
);
    localparam int NBE = DATA_W / BYTE_W;

    logic              ce;
    logic              oce;
    logic              wre;
    logic [NBE-1:0]    be;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic              clr_req;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;

    modport master (
        output ce, oce, wre, be, ad, din, clr_req,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  ce, oce, wre, be, ad, din, clr_req,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte lanes, collision modes, optional output register
// and a zero-fill engine.
//   state | meaning
//   IDLE  | user accesses honoured
//   CLEAR | engine zero-fills one word per cycle, user access blocked
module sp_ram_be #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 11,
    parameter int BYTE_W         = 8,
    parameter int READ_MODE      = 0,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic         clk,
    input logic         reset_n,
    sp_ram_be_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBE   = DATA_W / BYTE_W;

    typedef enum logic {IDLE, CLEAR} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy, access, wr_en, s1_load;
    logic              s1_new_q, valid_q;
    logic [DATA_W-1:0] rd_word, merged, s1_d, stage1_q, out_q;

    assign busy    = (state_q == CLEAR);
    assign access  = bus.ce & ~busy;
    assign wr_en   = access & bus.wre;
    assign rd_word = mem[bus.ad];

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NBE; i++) begin
            if (bus.be[i]) merged[i*BYTE_W +: BYTE_W] = bus.din[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) state_d = CLEAR;
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Array has no reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (bus.be[i]) mem[bus.ad][i*BYTE_W +: BYTE_W] <= bus.din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        s1_load = 1'b0;
        s1_d    = stage1_q;
        if (access) begin
            if (!bus.wre) begin
                s1_load = 1'b1;
                s1_d    = rd_word;
            end else if (WRITE_MODE == 1) begin
                s1_load = 1'b1;
                s1_d    = merged;
            end else if (WRITE_MODE == 2) begin
                s1_load = 1'b1;
                s1_d    = rd_word;
            end
        end
    end

    // s1_new marks stage1 data not yet handed to the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1_q <= '0;
            out_q    <= '0;
            s1_new_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            stage1_q <= s1_d;
            if (bus.oce) out_q <= stage1_q;
            s1_new_q <= s1_load | (s1_new_q & ~bus.oce);
            valid_q  <= (READ_MODE == 1) ? (bus.oce & s1_new_q) : s1_load;
        end
    end

    assign bus.dout       = (READ_MODE == 1) ? out_q : stage1_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench: five RAM configurations share one stimulus stream.
module tb_sp_ram_be;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0, oce = 1'b0, wre = 1'b0, clr_req = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [3:0]  ad = 4'd0;
    logic [15:0] din = 16'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: RM0/WM0, 1: WM1, 2: WM2, 3: RM1, 4: no clear on reset
    sp_ram_be_if #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8)) bi [5] ();

    for (genvar k = 0; k < 5; k++) begin : g_drv
        assign bi[k].ce      = ce;
        assign bi[k].oce     = oce;
        assign bi[k].wre     = wre;
        assign bi[k].be      = be;
        assign bi[k].ad      = ad;
        assign bi[k].din     = din;
        assign bi[k].clr_req = clr_req;
    end

    sp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bi[0]));
    sp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(1), .CLEAR_ON_RESET(1))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bi[1]));
    sp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(2), .CLEAR_ON_RESET(1))
        u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bi[2]));
    sp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .READ_MODE(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
        u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bi[3]));
    sp_ram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(0))
        u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bi[4]));

    typedef struct {
        logic        ce, wre;
        logic [1:0]  be;
        logic [3:0]  ad;
        logic [15:0] din;
        logic [15:0] d0, d1, d2;
        logic        v0, v1, v2;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(input logic c, input logic w, input logic [1:0] b,
                                input logic [3:0] a, input logic [15:0] di,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                                input logic f0, input logic f1, input logic f2);
        vec_t v;
        v.ce = c; v.wre = w; v.be = b; v.ad = a; v.din = di;
        v.d0 = e0; v.d1 = e1; v.d2 = e2;
        v.v0 = f0; v.v1 = f1; v.v2 = f2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce = 1'b0; wre = 1'b0; be = 2'b00; clr_req = 1'b0;
    endtask

    task automatic acc(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        ce = 1'b1; wre = w; ad = a; din = d; be = b;
        step();
    endtask

    // Counts edges until busy drops; optional one-cycle clr_req at edge index mid.
    task automatic count_busy(input string name, input int mid, input logic chk_valid);
        int n;
        n = 0;
        while (bi[0].busy === 1'b1 && n < 100) begin
            clr_req = (n == mid);
            step();
            n++;
            if (chk_valid) chk($sformatf("%s_valid_blocked_%0d", name, n), 32'(bi[1].dout_valid), 32'd0);
        end
        idle();
        chk($sformatf("%s_busy_cycles", name), 32'(n), 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            vecs[i] = mk(1, 0, 2'b00, 4'(i), 16'h0, 16'h0, 16'h0, 16'h0, 1, 1, 1);
        vecs[16] = mk(1, 1, 2'b11, 4'd3, 16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000, 0, 1, 1);
        vecs[17] = mk(1, 1, 2'b01, 4'd3, 16'h1234, 16'h0000, 16'hA534, 16'hA5A5, 0, 1, 1);
        vecs[18] = mk(1, 0, 2'b00, 4'd3, 16'h0000, 16'hA534, 16'hA534, 16'hA534, 1, 1, 1);
        vecs[19] = mk(1, 1, 2'b11, 4'd5, 16'h1111, 16'hA534, 16'h1111, 16'h0000, 0, 1, 1);
        vecs[20] = mk(1, 0, 2'b00, 4'd5, 16'h0000, 16'h1111, 16'h1111, 16'h1111, 1, 1, 1);
        vecs[21] = mk(1, 1, 2'b11, 4'd5, 16'h2222, 16'h1111, 16'h2222, 16'h1111, 0, 1, 1);
        vecs[22] = mk(1, 1, 2'b00, 4'd5, 16'hFFFF, 16'h1111, 16'h2222, 16'h2222, 0, 1, 1);
        vecs[23] = mk(1, 0, 2'b00, 4'd5, 16'h0000, 16'h2222, 16'h2222, 16'h2222, 1, 1, 1);
        vecs[24] = mk(1, 1, 2'b10, 4'd3, 16'h5A00, 16'h2222, 16'h5A34, 16'hA534, 0, 1, 1);
        vecs[25] = mk(0, 0, 2'b00, 4'd3, 16'h0000, 16'h2222, 16'h5A34, 16'hA534, 0, 0, 0);
        vecs[26] = mk(1, 0, 2'b00, 4'd3, 16'h0000, 16'h5A34, 16'h5A34, 16'h5A34, 1, 1, 1);

        // Reset release and power-on clear, with blocked writes to addr 2.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bi[0].dout), 32'd0);
        chk("rst_valid", 32'(bi[0].dout_valid), 32'd0);
        reset_n = 1'b1;
        chk("por_busy", 32'(bi[0].busy), 32'd1);
        chk("no_clear_busy", 32'(bi[4].busy), 32'd0);
        ce = 1'b1; wre = 1'b1; be = 2'b11; ad = 4'd2; din = 16'hFFFF;
        count_busy("por", -1, 1'b1);

        foreach (vecs[i]) begin
            ce = vecs[i].ce; wre = vecs[i].wre; be = vecs[i].be; ad = vecs[i].ad; din = vecs[i].din;
            step();
            chk($sformatf("v%0d_dout_wm0", i), 32'(bi[0].dout), 32'(vecs[i].d0));
            chk($sformatf("v%0d_valid_wm0", i), 32'(bi[0].dout_valid), 32'(vecs[i].v0));
            chk($sformatf("v%0d_dout_wm1", i), 32'(bi[1].dout), 32'(vecs[i].d1));
            chk($sformatf("v%0d_valid_wm1", i), 32'(bi[1].dout_valid), 32'(vecs[i].v1));
            chk($sformatf("v%0d_dout_wm2", i), 32'(bi[2].dout), 32'(vecs[i].d2));
            chk($sformatf("v%0d_valid_wm2", i), 32'(bi[2].dout_valid), 32'(vecs[i].v2));
        end
        idle();

        // Output register: hold while oce=0, single valid pulse on load.
        oce = 1'b0;
        acc(1, 4'd1, 16'h0101, 2'b11);
        acc(1, 4'd2, 16'h0202, 2'b11);
        acc(1, 4'd3, 16'h0303, 2'b11);
        acc(1, 4'd7, 16'hBEEF, 2'b11);
        acc(0, 4'd7, 16'h0000, 2'b00);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rm1_hold_dout_%0d", i), 32'(bi[3].dout), 32'h0);
            chk($sformatf("rm1_hold_valid_%0d", i), 32'(bi[3].dout_valid), 32'd0);
        end
        oce = 1'b1;
        step();
        chk("rm1_load_dout", 32'(bi[3].dout), 32'hBEEF);
        chk("rm1_load_valid", 32'(bi[3].dout_valid), 32'd1);
        step();
        chk("rm1_reload_dout", 32'(bi[3].dout), 32'hBEEF);
        chk("rm1_reload_valid", 32'(bi[3].dout_valid), 32'd0);
        begin
            logic [15:0] ed [5];
            logic        ev [5];
            ed[0] = 16'hBEEF; ev[0] = 1'b0;
            ed[1] = 16'h0101; ev[1] = 1'b1;
            ed[2] = 16'h0202; ev[2] = 1'b1;
            ed[3] = 16'h0303; ev[3] = 1'b1;
            ed[4] = 16'h0303; ev[4] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (i < 3) begin
                    ce = 1'b1; wre = 1'b0; ad = 4'(i + 1);
                end else begin
                    idle();
                end
                step();
                chk($sformatf("rm1_b2b_dout_%0d", i), 32'(bi[3].dout), 32'(ed[i]));
                chk($sformatf("rm1_b2b_valid_%0d", i), 32'(bi[3].dout_valid), 32'(ev[i]));
            end
        end
        oce = 1'b0;

        // clr_req together with a write; a second request mid-clear is ignored.
        clr_req = 1'b1;
        acc(1, 4'd9, 16'h00FF, 2'b11);
        idle();
        chk("clr_busy_rise", 32'(bi[0].busy), 32'd1);
        chk("clr_write_done", 32'(bi[1].dout), 32'h00FF);
        chk("clr_write_valid", 32'(bi[1].dout_valid), 32'd1);
        count_busy("clr", 5, 1'b0);
        acc(0, 4'd9, 16'h0, 2'b00);
        idle();
        chk("clr_addr9_dout", 32'(bi[0].dout), 32'h0);
        chk("clr_addr9_valid", 32'(bi[0].dout_valid), 32'd1);

        // Reset in the middle of a clear restarts it from address 0.
        acc(1, 4'd3, 16'h7777, 2'b11);
        clr_req = 1'b1;
        acc(0, 4'd3, 16'h0, 2'b00);
        idle();
        chk("mid_pre_dout", 32'(bi[0].dout), 32'h7777);
        chk("mid_pre_busy", 32'(bi[0].busy), 32'd1);
        repeat (8) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(bi[0].dout), 32'h0);
        chk("mid_rst_valid", 32'(bi[0].dout_valid), 32'd0);
        chk("mid_rst_dout_wm1", 32'(bi[1].dout), 32'h0);
        chk("mid_rst_dout_rm1", 32'(bi[3].dout), 32'h0);
        chk("mid_rst_busy", 32'(bi[0].busy), 32'd1);
        chk("mid_rst_busy_nc", 32'(bi[4].busy), 32'd0);
        step();
        reset_n = 1'b1;
        count_busy("restart", -1, 1'b0);
        acc(0, 4'd3, 16'h0, 2'b00);
        idle();
        chk("restart_addr3", 32'(bi[0].dout), 32'h0);
        chk("restart_addr3_valid", 32'(bi[0].dout_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
- Parametrised single-port synchronous RAM for the scpu memory subsystem, replacing the fixed 2K x 8 vendor block wrapper.
- Adds:
  - generic width and depth
  - per-byte write enables
  - selectable write-read collision modes
  - an optional output pipeline register
  - a built-in clear engine that zero-fills the array after reset or on request.
- Sits between the CPU load/store unit and the address decoder. It is inferred from behavioural RTL, with no vendor primitive instantiated.

Parameters:
- DATA_W, 16: word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 11: address width; DEPTH = 2**ADDR_W words.
- BYTE_W, 8: byte-lane width; NBE = DATA_W/BYTE_W lanes.
- READ_MODE, 0: 0 = bypass (1-cycle read latency); 1 = pipeline (2-cycle latency, output register gated by oce).
- WRITE_MODE, 0: 0 = normal (dout holds on write); 1 = write-through; 2 = read-before-write.
- CLEAR_ON_RESET, 1: 1 = run the clear engine on reset release; 0 = come out of reset idle.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  access enable.
- oce  in  1  output register enable; used only when READ_MODE=1.
- wre  in  1  1 = write, 0 = read, qualified by ce.
- be  in  NBE  byte-lane write enables; bit i covers din[i*BYTE_W +: BYTE_W].
- ad  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- clr_req  in  1  single-cycle request to zero the whole array.
- dout  out  DATA_W  read data.
- dout_valid  out  1  pulses for the cycle in which dout first shows new access data.
- busy  out  1  high while the clear engine owns the array.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and reset_n.
- Reset (reset_n=0, asynchronous):
  - dout=0, dout_valid=0; internal read register stage1 and the output register are 0.
  - clr_addr is set to 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1 (busy=1), else IDLE (busy=0).
  - Array contents are not touched by reset itself.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR: on the edge where clr_req=1. busy rises the following cycle.
  - CLEAR: writes all-zero to mem[clr_addr] each cycle and increments clr_addr.
  - CLEAR -> IDLE: after the write to DEPTH-1, clr_addr wraps to 0 and busy falls. A clear takes exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored; the clear does not restart.
  - reset_n asserted mid-clear restarts the clear from address 0 (if CLEAR_ON_RESET=1).
- User access is honoured only when ce=1 and busy=0. While busy=1, ce/wre are ignored: no write, stage1 holds, dout_valid=0.
  - clr_req together with a user access in IDLE: the access completes in that cycle and the clear starts next cycle.
- Write (ce=1, wre=1):
  - Lanes with be[i]=1 take din; other lanes keep their old value.
  - be=0 with wre=1 writes nothing, but stage1 still follows WRITE_MODE.
- stage1 update on the clock edge:
  - Read (ce=1, wre=0): stage1 <= mem[ad].
  - Write, WRITE_MODE 0: stage1 holds.
  - Write, WRITE_MODE 1: stage1 <= merged new word.
  - Write, WRITE_MODE 2: stage1 <= old word at ad.
  - ce=0: stage1 holds.
- READ_MODE 0:
  - dout = stage1, data visible 1 cycle after the access edge.
  - dout_valid=1 in the cycle after any read, or any write with WRITE_MODE 1 or 2.
- READ_MODE 1:
  - The output register loads stage1 on edges where oce=1; dout = output register.
  - Data appears 2 cycles after the access if oce=1 on the second edge.
  - dout_valid=1 only for the cycle after an oce load of a stage1 value not previously loaded. While oce=0, dout holds.
- Back-to-back accesses are fully pipelined: one access per cycle, no bubbles.
- Same-address read directly after a write returns the written data.

Test Plan:
- Test config: DATA_W=16, ADDR_W=4, READ_MODE=0, WRITE_MODE=0, unless noted.
- Reset release with CLEAR_ON_RESET=1:
  - Expect busy=1 for exactly 16 cycles, then busy=0.
  - Expect reads of addresses 0..15 to return 0x0000.
  - Expect ce pulses during busy to produce no write and dout_valid=0.
- Byte enables:
  - Write 0xA5A5 to addr 3 with be=2'b11, then 0x1234 with be=2'b01.
  - Read addr 3 -> dout=0xA534 one cycle later, with dout_valid=1.
- WRITE_MODE 0/1/2: addr 5 holds 0x1111; write 0x2222 with be=2'b11.
  - Mode 0: dout stays at its prior value, dout_valid=0.
  - Mode 1: dout=0x2222.
  - Mode 2: dout=0x1111.
- READ_MODE=1:
  - Read addr 7 (holding 0xBEEF) with oce=0 for 3 cycles, then oce=1.
  - Expect dout=0xBEEF only on the cycle after the oce edge, with a single dout_valid pulse.
  - Back-to-back reads of addrs 1,2,3 with oce=1 -> data on cycles 2,3,4.
- clr_req:
  - Assert clr_req concurrent with a write of 0x00FF to addr 9.
  - Expect busy to rise the next cycle and 16 clear cycles, after which addr 9 reads 0x0000.
  - A second clr_req mid-clear does not extend busy.
- reset_n pulsed low at clear cycle 8:
  - Expect dout=0 and dout_valid=0 immediately (asynchronously).
  - After release, the clear restarts and busy lasts 16 full cycles.
